// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module  : seq_pattern_tx
// Brief   : Bit-serial pattern transmitter. It captures a PAT_W-bit pattern on
//           start and sends it MSB-first (repeat_n+1) times back-to-back.
//           `define SEQ_TX_PARITY_EN appends an even-parity bit to every frame.
// Revision: 1.0  initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int c_FRAME = PAT_W + 1;
`else
    localparam int c_FRAME = PAT_W;
`endif
    localparam int                 c_BIT_W = $clog2(PAT_W + 1);
    localparam logic [c_BIT_W-1:0] c_LAST  = c_BIT_W'(c_FRAME - 1);
`ifdef SEQ_TX_PARITY_EN
    localparam logic [c_BIT_W-1:0] c_LSB   = c_BIT_W'(PAT_W - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_shreg;
    logic [c_BIT_W-1:0] r_bit;
    logic [CNT_W-1:0]   r_rep;
    logic               r_sout;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
`ifdef SEQ_TX_PARITY_EN
    logic               r_par;
`endif

    // r_bit is the frame position of the bit currently on sout; r_shreg
    // holds the data bits still to come, next one in its MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_shreg <= '0;
            r_bit   <= '0;
            r_rep   <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat   <= pattern;
                        r_shreg <= {pattern[PAT_W-2:0], 1'b0};
                        r_rep   <= repeat_n;
                        r_bit   <= '0;
                        r_sout  <= pattern[PAT_W-1];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef SEQ_TX_PARITY_EN
                        r_par   <= ^pattern;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_bit == c_LAST) begin
                        if (r_rep != '0) begin
                            // Restart at the MSB on the very next edge: no gap.
                            r_rep   <= r_rep - CNT_W'(1);
                            r_bit   <= '0;
                            r_sout  <= r_pat[PAT_W-1];
                            r_shreg <= {r_pat[PAT_W-2:0], 1'b0};
                        end else begin
                            r_bit   <= '0;
                            r_shreg <= '0;
                            r_sout  <= 1'b0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
`ifdef SEQ_TX_PARITY_EN
                    end else if (r_bit == c_LSB) begin
                        r_bit  <= r_bit + c_BIT_W'(1);
                        r_sout <= r_par;
`endif
                    end else begin
                        r_bit   <= r_bit + c_BIT_W'(1);
                        r_sout  <= r_shreg[PAT_W-1];
                        r_shreg <= {r_shreg[PAT_W-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sout  <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
